// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if
//   Bundles the handshake and data signals between NUM_CH upstream producers,
//   the stream multiplexer and one downstream consumer.
//   slave  : multiplexer side (takes in_*, out_ready; drives in_ready, out_*)
//   master : environment side (drives in_*, out_ready; observes the rest)
//   in_valid/in_last/in_ready : one bit per channel
//   in_data                   : flattened, channel i at [i*DATA_W +: DATA_W]
//   out_valid/out_data/out_last/out_ch/out_ready : merged output stream
interface stream_mux_rr_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = $clog2(NUM_CH)
);
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH-1:0]        in_last;
   logic [NUM_CH-1:0]        in_ready;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_last;
   logic [SEL_W-1:0]         out_ch;
   logic                     out_ready;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_ch
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_ch
   );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   Merges NUM_CH valid/ready streams onto one registered output stream.
//   The source is picked by `sel` (mode 0) or by a round-robin arbiter
//   (mode 1); once a packet starts, the grant is locked to that channel until
//   its last beat is accepted.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   mode  : 0 = manual select, 1 = round-robin
//   sel   : channel index used in manual mode
//   bus   : stream bundle (slave modport), see stream_mux_rr_if
//   busy  : high while a packet is in progress
module stream_mux_rr #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   stream_mux_rr_if.slave   bus,
   output logic             busy
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

   state_t            state, state_nxt;
   logic [SEL_W-1:0]  lock_ch;
   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  g;
   logic              gv;
   logic              space;
   logic              accept;
   logic              v_g;
   logic              l_g;
   logic [DATA_W-1:0] d_g;

   // The output holding stage can take a new beat when empty or draining.
   assign space = !bus.out_valid || bus.out_ready;

   // Grant selection. In round-robin the search starts just after the last
   // packet's channel; k runs downwards so the nearest valid channel wins.
   always_comb begin
      g  = '0;
      gv = 1'b0;
      if (state == LOCKED) begin
         g  = lock_ch;
         gv = 1'b1;
      end else if (!mode) begin
         g  = sel;
         gv = ({1'b0, sel} < NUM_CH_W);
      end else begin
         for (int k = NUM_CH; k >= 1; k--) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (i == (int'(rr_ptr) + k) % NUM_CH && bus.in_valid[i]) begin
                  g  = SEL_W'(i);
                  gv = 1'b1;
               end
            end
         end
      end
   end

   // Pick the granted channel's beat; only feeds registers, never outputs.
   always_comb begin
      v_g = 1'b0;
      l_g = 1'b0;
      d_g = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (g == SEL_W'(i)) begin
            v_g = bus.in_valid[i];
            l_g = bus.in_last[i];
            d_g = bus.in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // rst_n gates ready so no channel sees a handshake while reset is held.
   always_comb begin
      bus.in_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         bus.in_ready[i] = rst_n && gv && space && (g == SEL_W'(i));
      end
   end

   assign accept = gv && space && v_g;

   always_comb begin
      state_nxt = state;
      if (accept) begin
         if (state == IDLE && !l_g) begin
            state_nxt = LOCKED;
         end else if (state == LOCKED && l_g) begin
            state_nxt = IDLE;
         end
      end
   end

   assign busy = (state == LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lock_ch   <= '0;
         rr_ptr    <= SEL_W'(NUM_CH - 1);
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.out_ch    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= d_g;
            bus.out_last  <= l_g;
            bus.out_ch    <= g;
            if (state == IDLE && !l_g) begin
               lock_ch <= g;
            end
            if (l_g) begin
               rr_ptr <= g;
            end
         end else if (space) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
//   Bench for stream_mux_rr. Per-channel source queues feed the 4-channel
//   instance; expected output beats are queued as stimulus is issued and a
//   monitor pops and compares on every output transfer. A 3-channel
//   instance covers the out-of-range select case.
module tb_stream_mux_rr;

   typedef struct packed {
      logic       v;
      logic       last;
      logic [7:0] data;
   } beat_t;

   typedef struct packed {
      logic [1:0] ch;
      logic       last;
      logic [7:0] data;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       mode;
   logic [1:0] sel;
   logic       busy;
   logic       mode3;
   logic [1:0] sel3;
   logic       busy3;

   int total = 0;
   int bad   = 0;

   beat_t src_q [4][$];
   exp_t  exp_q [$];
   logic [3:0] acc;
   logic [3:0] bub;

   stream_mux_rr_if #(.NUM_CH(4), .DATA_W(8)) bus ();
   stream_mux_rr_if #(.NUM_CH(3), .DATA_W(8)) bus3 ();

   stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .bus(bus), .busy(busy)
   );

   stream_mux_rr #(.NUM_CH(3), .DATA_W(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .bus(bus3), .busy(busy3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_src(input int ch, input logic v, input logic last, input logic [7:0] d);
      beat_t b;
      b.v = v; b.last = last; b.data = d;
      src_q[ch].push_back(b);
   endtask

   task automatic push_exp(input logic [1:0] ch, input logic last, input logic [7:0] d);
      exp_t e;
      e.ch = ch; e.last = last; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      while (exp_q.size() > 0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   // Accepts are sampled late in the low phase, after all inputs settled.
   always @(negedge clk) begin
      #3;
      acc = bus.in_valid & bus.in_ready;
   end

   // Source driver: retire accepted beats / shown bubbles, present the next.
   initial begin
      beat_t b;
      bus.in_valid = '0;
      bus.in_data  = '0;
      bus.in_last  = '0;
      bub = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0 && (acc[i] || bub[i])) void'(src_q[i].pop_front());
            bub[i] = 1'b0;
            if (src_q[i].size() > 0) begin
               b = src_q[i][0];
               bus.in_valid[i]       = b.v;
               bus.in_last[i]        = b.last;
               bus.in_data[i*8 +: 8] = b.data;
               bub[i]                = !b.v;
            end else begin
               bus.in_valid[i]       = 1'b0;
               bus.in_last[i]        = 1'b0;
               bus.in_data[i*8 +: 8] = 8'h00;
            end
         end
      end
   end

   // Monitor: every output transfer must match the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      #3;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mon_unexpected actual=ch%0d/%0h required=no beat",
                     bus.out_ch, bus.out_data);
         end else begin
            e = exp_q.pop_front();
            chk("mon_beat", {21'd0, bus.out_ch, bus.out_last, bus.out_data},
                {21'd0, e.ch, e.last, e.data});
         end
      end
   end

   initial begin
      rst_n = 1'b1;
      mode = 1'b0; sel = 2'd0;
      mode3 = 1'b0; sel3 = 2'd0;
      bus.out_ready  = 1'b0;
      bus3.in_valid  = '0;
      bus3.in_data   = '0;
      bus3.in_last   = '0;
      bus3.out_ready = 1'b0;
      #2;

      // Reset with random activity on the inputs
      rst_n = 1'b0;
      mode = 1'($urandom_range(0, 1));
      sel  = 2'($urandom_range(0, 3));
      bus.out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
         push_src(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         push_src(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_out_data",  bus.out_data, 0);
         chk("rst_out_last",  bus.out_last, 0);
         chk("rst_out_ch",    bus.out_ch, 0);
         chk("rst_busy",      busy, 0);
         chk("rst_in_ready",  bus.in_ready, 0);
      end

      // Full-rate recovery: ch0 streams 6 beats as reset releases
      for (int i = 0; i < 4; i++) src_q[i].delete();
      mode = 1'b0; sel = 2'd0; bus.out_ready = 1'b1;
      for (int d = 1; d <= 6; d++) begin
         push_src(0, 1'b1, (d == 6), 8'(d));
         push_exp(2'd0, (d == 6), 8'(d));
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rec_out_valid", bus.out_valid, 1);
         if (k == 0) chk("rec_busy_set", busy, 1);
      end
      @(negedge clk);
      chk("rec_out_idle", bus.out_valid, 0);
      chk("rec_busy_clr", busy, 0);
      drain("rec_drain");

      // Manual sel=2 packet; sel flipped to 0 mid-packet, ch0 waiting
      sel = 2'd2;
      push_src(2, 1'b1, 1'b0, 8'hA1);
      push_src(2, 1'b1, 1'b0, 8'hA2);
      push_src(2, 1'b1, 1'b1, 8'hA3);
      push_src(0, 1'b1, 1'b1, 8'hB0);
      push_exp(2'd2, 1'b0, 8'hA1);
      push_exp(2'd2, 1'b0, 8'hA2);
      push_exp(2'd2, 1'b1, 8'hA3);
      push_exp(2'd0, 1'b1, 8'hB0);
      nclk(2);
      chk("man_busy_a1", busy, 1);
      chk("man_ready_a1", bus.in_ready, 4'b0100);
      sel = 2'd0;
      @(negedge clk);
      chk("man_busy_a2", busy, 1);
      chk("man_ready_lock", bus.in_ready, 4'b0100);
      @(negedge clk);
      chk("man_busy_a3", busy, 0);
      chk("man_ready_sel0", bus.in_ready, 4'b0001);
      drain("man_drain");

      // Round-robin fairness from reset: four channels, three beats each
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mode = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) begin
            push_src(i, 1'b1, 1'b1, 8'h10 + 8'(i));
            push_exp(2'(i), 1'b1, 8'h10 + 8'(i));
         end
      end
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("rr_out_valid", bus.out_valid, 1);
      end
      drain("rr_drain");

      // Packet lock on ch1 with a gap; ch0 and ch3 contend
      push_src(1, 1'b1, 1'b0, 8'hC1);
      push_src(1, 1'b1, 1'b0, 8'hC2);
      push_src(1, 1'b0, 1'b0, 8'h00);
      push_src(1, 1'b1, 1'b1, 8'hC3);
      push_exp(2'd1, 1'b0, 8'hC1);
      push_exp(2'd1, 1'b0, 8'hC2);
      push_exp(2'd1, 1'b1, 8'hC3);
      nclk(2);
      chk("lock_busy", busy, 1);
      push_src(0, 1'b1, 1'b1, 8'h30);
      push_src(3, 1'b1, 1'b1, 8'h33);
      push_exp(2'd3, 1'b1, 8'h33);
      push_exp(2'd0, 1'b1, 8'h30);
      @(negedge clk);
      chk("lock_ready", bus.in_ready, 4'b0010);
      @(negedge clk);
      chk("lock_gap_valid", bus.out_valid, 0);
      chk("lock_gap_busy", busy, 1);
      chk("lock_gap_ready", bus.in_ready, 4'b0010);
      drain("lock_drain");

      // Backpressure: 0x5C held for five cycles, then drained with 0x5D loaded
      mode = 1'b0; sel = 2'd1;
      push_src(1, 1'b1, 1'b1, 8'h5C);
      push_src(1, 1'b1, 1'b1, 8'h5D);
      push_exp(2'd1, 1'b1, 8'h5C);
      push_exp(2'd1, 1'b1, 8'h5D);
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_data", bus.out_data, 8'h5C);
         chk("bp_ch", bus.out_ch, 1);
         chk("bp_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_next_valid", bus.out_valid, 1);
      chk("bp_next_data", bus.out_data, 8'h5D);
      drain("bp_drain");

      // Reset in the middle of a held, locked packet
      sel = 2'd2;
      bus.out_ready = 1'b0;
      push_src(2, 1'b1, 1'b0, 8'hE1);
      nclk(2);
      chk("mid_busy", busy, 1);
      chk("mid_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", bus.out_data, 0);
      @(negedge clk);
      chk("mid_rst_ready", bus.in_ready, 0);
      for (int i = 0; i < 4; i++) src_q[i].delete();
      sel = 2'd3;
      bus.out_ready = 1'b1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("mid_post_valid", bus.out_valid, 0);
         chk("mid_post_busy", busy, 0);
      end

      // Three-channel instance: sel=3 is out of range
      bus3.in_valid  = 3'b111;
      bus3.in_last   = 3'b111;
      bus3.in_data   = {8'h72, 8'h71, 8'h70};
      bus3.out_ready = 1'b1;
      mode3 = 1'b0;
      sel3  = 2'd3;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("oor_ready", bus3.in_ready, 0);
         chk("oor_valid", bus3.out_valid, 0);
      end
      sel3 = 2'd2;
      #1;
      chk("ch3_ready", bus3.in_ready, 3'b100);
      @(negedge clk);
      chk("ch3_valid", bus3.out_valid, 1);
      chk("ch3_data", bus3.out_data, 8'h72);
      chk("ch3_ch", bus3.out_ch, 2);
      bus3.in_valid = '0;
      nclk(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer with valid/ready handshakes, packet-level grant locking and a registered output stage. It merges `NUM_CH` upstream streams onto one downstream stream. The channel is chosen either by an explicit select input (manual mode) or by a round-robin arbiter (RR mode). It is the sequential, generalised successor of the fixed 4:1 combinational selectors used in the datapath, and sits wherever several producers share one consumer.

## Interface
- `NUM_CH`, 4, number of input channels (≥2)
- `DATA_W`, 8, data width per channel
- `SEL_W`, `$clog2(NUM_CH)`, select/channel-index width (derived; do not override)

- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `mode`  in  1  0 = manual select, 1 = round-robin
- `sel`  in  SEL_W  channel index used in manual mode
- `in_valid`  in  NUM_CH  per-channel valid
- `in_data`  in  NUM_CH*DATA_W  flattened; channel i occupies bits [i*DATA_W +: DATA_W]
- `in_last`  in  NUM_CH  per-channel end-of-packet flag
- `in_ready`  out  NUM_CH  per-channel ready
- `out_valid`  out  1  output beat valid
- `out_data`  out  DATA_W  output data
- `out_last`  out  1  output end-of-packet
- `out_ch`  out  SEL_W  source channel of the current output beat
- `out_ready`  in  1  downstream ready
- `busy`  out  1  high while a packet is in progress (state LOCKED)

## Operation
- A transfer on a side occurs when valid && ready on a rising edge. A transfer on input i is called "accept".
- Output register: `out_valid/out_data/out_last/out_ch` form a single holding stage. `space = !out_valid || out_ready`.
- Grant `g` and `gv` (grant valid):
  - IDLE, mode 0: g = `sel`; gv = (`sel` < NUM_CH).
  - IDLE, mode 1: g = first i with `in_valid[i]` searching `rr_ptr+1, rr_ptr+2, …` modulo NUM_CH; gv = |`in_valid`.
  - LOCKED: g = `lock_ch`; gv = 1. `mode` and `sel` are ignored.
- `in_ready[i] = gv && (i == g) && space`. All other channels see ready = 0.
- On accept from g: load `out_data` = in_data[g], `out_last` = in_last[g], `out_ch` = g, `out_valid` = 1.
- If `space` && no accept: `out_valid` ← 0. Output fields retain their values.
- If `!space`, the output register holds; data, last and ch stay stable until `out_ready`.
- State machine:
  - IDLE → LOCKED on accept with in_last = 0; `lock_ch` ← g.
  - IDLE stays IDLE on accept with in_last = 1 (single-beat packet).
  - LOCKED → IDLE on accept with in_last = 1.
  - LOCKED stays LOCKED otherwise, including cycles where the locked channel has in_valid = 0.
- `rr_ptr` ← g on every accept with in_last = 1, in either mode.
- `busy` = (state == LOCKED).
- Switching `mode` or `sel` mid-packet has no effect until the packet completes.

## Timing
- Reset (async assert, sync-safe deassert) values:
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_ch` = 0, `busy` = 0
  - state = IDLE, `lock_ch` = 0, `rr_ptr` = NUM_CH-1, so ch0 has first RR priority
- During reset, `in_ready` = 0.
- Reset mid-packet discards the held beat and the lock. No beat is emitted after deassert until a new accept.
- Latency: input accept at edge k → `out_valid` = 1 with that data after edge k (visible in cycle k+1).
- Throughput: 1 beat/cycle when `out_ready` is held high. There is no bubble between packets or on a channel switch.
- `in_ready` is combinational from `out_valid`, `out_ready`, state, `mode`, `sel` and (RR mode, IDLE only) `in_valid`. There is no combinational path from `in_data`/`in_last` to any output.
- `out_valid` never drops without `out_ready` = 1 (AXI-stream rule).
- Simultaneous output drain and input accept in the same cycle is required (full-rate pass-through).

## Test plan
- Reset check: assert `rst_n` = 0 with random inputs → all outputs at reset values and `in_ready` = 0.
- Full-rate reset recovery: release reset with ch0 streaming and `out_ready` = 1 → first beat appears one cycle after the first accept, followed by one beat per cycle.
- Manual mode, NUM_CH = 4, `sel` = 2: ch2 sends 0xA1, 0xA2, 0xA3 (last on 0xA3) with `out_ready` = 1 → out_data sequence A1, A2, A3 one cycle delayed, `out_ch` = 2 on every beat, `busy` = 1 after A1 and cleared after A3. Flip `sel` to 0 after A1 → no effect until after A3.
- RR fairness: all four channels continuously send single-beat packets (last = 1) with data = 0x10+i → `out_ch` sequence 0, 1, 2, 3, 0, 1, … at one per cycle.
- Packet lock: ch1 sends a 3-beat packet while ch0 and ch3 are valid. Insert a gap with in_valid[1] = 0 mid-packet → `in_ready[0]` and `in_ready[3]` stay 0, the output shows only ch1 beats, and the next grant after ch1's last goes to ch3 (rr_ptr = 1, ch2 idle).
- Backpressure: hold `out_ready` = 0 for 5 cycles with a beat 0x5C held → `out_valid`, `out_data` = 0x5C and `out_ch` stay stable and all `in_ready` = 0. Release `out_ready` → 0x5C transfers and the next beat is loaded the same cycle.
- Out-of-range select: NUM_CH = 3, manual `sel` = 3 → all `in_ready` = 0 and `out_valid` stays 0.
